// File: rtl/sd_rrmux_output.sv
// sd_rrmux_output: N:1 round-robin multiplexer with a registered output stage.
// In packet mode (mode=1) the grant is held from the first word of a packet
// until the word carrying end-of-packet has been accepted.
module sd_rrmux_output #(
  parameter int unsigned width  = 8,
  parameter int unsigned inputs = 4,
  parameter int unsigned mode   = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  input  logic [inputs-1:0]       c_eop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [inputs-1:0]       p_grant,
  output logic                    p_eop
);

  localparam int unsigned IdxW = (inputs > 1) ? $clog2(inputs) : 1;
  // One extra bit so last+k never overflows before the wrap subtraction.
  localparam logic [IdxW:0]   NumIn    = (IdxW+1)'(inputs);
  localparam logic [IdxW-1:0] LastInit = IdxW'(inputs - 1);

  logic [IdxW-1:0]   last_q;
  logic              lock_q;
  logic [IdxW-1:0]   lock_idx_q;
  logic              p_srdy_q;
  logic [width-1:0]  p_data_q;
  logic [inputs-1:0] p_grant_q;
  logic              p_eop_q;

  logic              ready;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW:0]     cand;
  logic [width-1:0]  sel_data;
  logic              sel_eop;
  logic              xfer;

  // The output register can take a new word when empty or being drained.
  assign ready = p_drdy | ~p_srdy_q;

  // Arbiter: locked requester only, otherwise first active after last winner.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = lock_idx_q;
    cand      = '0;
    if (lock_q) begin
      sel_valid = 1'b1;
    end else begin
      for (int k = 1; k <= int'(inputs); k++) begin
        cand = {1'b0, last_q} + (IdxW+1)'(k);
        if (cand >= NumIn) begin
          cand = cand - NumIn;
        end
        if (!sel_valid && c_srdy[cand[IdxW-1:0]]) begin
          sel_valid = 1'b1;
          sel_idx   = cand[IdxW-1:0];
        end
      end
    end
  end

  // Offer the slot to the selected requester only while the output can accept.
  always_comb begin
    c_drdy = '0;
    if (ready && sel_valid) begin
      c_drdy[sel_idx] = 1'b1;
    end
  end

  assign xfer = |(c_srdy & c_drdy);

  // Data/eop mux for the selected requester.
  always_comb begin
    sel_data = c_data[width-1:0];
    sel_eop  = c_eop[0];
    for (int i = 0; i < int'(inputs); i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_data = c_data[i*width +: width];
        sel_eop  = c_eop[i];
      end
    end
  end

  // Control state and output flags; reset discards any held word and lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_srdy_q   <= 1'b0;
      p_grant_q  <= '0;
      p_eop_q    <= 1'b0;
      last_q     <= LastInit;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      p_srdy_q <= xfer | (p_srdy_q & ~p_drdy);
      if (xfer) begin
        p_grant_q <= c_drdy;
        p_eop_q   <= sel_eop;
        last_q    <= sel_idx;
        if (mode == 1) begin
          lock_q     <= ~sel_eop;
          lock_idx_q <= sel_idx;
        end
      end
    end
  end

  // Output data carries no reset; it is only meaningful while p_srdy is high.
  always_ff @(posedge clk) begin
    if (xfer) begin
      p_data_q <= sel_data;
    end
  end

  assign p_srdy  = p_srdy_q;
  assign p_data  = p_data_q;
  assign p_grant = p_grant_q;
  assign p_eop   = p_eop_q;

endmodule

// File: tb/tb_sd_rrmux_output.sv
// Bench for sd_rrmux_output: two instances (4 inputs packet mode, 3 inputs
// word mode), directed scenarios plus randomized traffic against a queue model.
module tb_sd_rrmux_output;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // Instance A: inputs=4, mode=1
  logic [3:0]   a_c_srdy, a_c_drdy, a_c_eop, a_p_grant;
  logic [4*W-1:0] a_c_data;
  logic         a_p_srdy, a_p_drdy, a_p_eop;
  logic [W-1:0] a_p_data;
  // Instance B: inputs=3, mode=0
  logic [2:0]   b_c_srdy, b_c_drdy, b_c_eop, b_p_grant;
  logic [3*W-1:0] b_c_data;
  logic         b_p_srdy, b_p_drdy, b_p_eop;
  logic [W-1:0] b_p_data;

  // Stimulus, indexed by instance
  logic [3:0]   srdy [2];
  logic [3:0]   eop  [2];
  logic [W-1:0] wd   [2][4];
  logic         pdrdy[2];

  assign a_c_srdy = srdy[0];
  assign a_c_eop  = eop[0];
  assign a_c_data = {wd[0][3], wd[0][2], wd[0][1], wd[0][0]};
  assign a_p_drdy = pdrdy[0];
  assign b_c_srdy = srdy[1][2:0];
  assign b_c_eop  = eop[1][2:0];
  assign b_c_data = {wd[1][2], wd[1][1], wd[1][0]};
  assign b_p_drdy = pdrdy[1];

  // Observed outputs, indexed by instance
  logic [3:0]   o_cdrdy[2];
  logic [3:0]   o_grant[2];
  logic         o_psrdy[2];
  logic         o_peop [2];
  logic [W-1:0] o_pdata[2];
  assign o_cdrdy[0] = a_c_drdy;
  assign o_cdrdy[1] = {1'b0, b_c_drdy};
  assign o_grant[0] = a_p_grant;
  assign o_grant[1] = {1'b0, b_p_grant};
  assign o_psrdy[0] = a_p_srdy;
  assign o_psrdy[1] = b_p_srdy;
  assign o_peop[0]  = a_p_eop;
  assign o_peop[1]  = b_p_eop;
  assign o_pdata[0] = a_p_data;
  assign o_pdata[1] = b_p_data;

  sd_rrmux_output #(.width(W), .inputs(4), .mode(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .c_srdy(a_c_srdy), .c_drdy(a_c_drdy), .c_data(a_c_data), .c_eop(a_c_eop),
    .p_srdy(a_p_srdy), .p_drdy(a_p_drdy), .p_data(a_p_data), .p_grant(a_p_grant),
    .p_eop(a_p_eop)
  );

  sd_rrmux_output #(.width(W), .inputs(3), .mode(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .c_srdy(b_c_srdy), .c_drdy(b_c_drdy), .c_data(b_c_data), .c_eop(b_c_eop),
    .p_srdy(b_p_srdy), .p_drdy(b_p_drdy), .p_data(b_p_data), .p_grant(b_p_grant),
    .p_eop(b_p_eop)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model state
  int   n_of   [2] = '{4, 3};
  int   mode_of[2] = '{1, 0};
  int   m_last [2];
  bit   m_lock [2];
  int   m_lidx [2];
  bit   m_valid[2];
  bit   m_xfer [2];
  int   m_win  [2];
  logic [3:0] exp_cdrdy[2];
  bit   exp_psrdy[2];
  bit   mon_en;
  int   wcnt[3];

  typedef struct packed {
    logic [3:0]   grant;
    logic [W-1:0] data;
    logic         eop;
  } item_t;
  item_t sbq0[$];
  item_t sbq1[$];

  function automatic void sb_push(int d, item_t it);
    if (d == 0) sbq0.push_back(it);
    else        sbq1.push_back(it);
  endfunction

  function automatic int sb_size(int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic item_t sb_pop(int d);
    return (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
  endfunction

  // Predict this cycle's arbitration outcome and push the word that will emerge.
  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int  n   = n_of[d];
      int  win = -1;
      bit  rdy = pdrdy[d] || !m_valid[d];
      bit  x;
      if (m_lock[d]) begin
        win = m_lidx[d];
      end else begin
        for (int k = 1; k <= n; k++) begin
          int c = (m_last[d] + k) % n;
          if (win < 0 && srdy[d][c]) win = c;
        end
      end
      exp_cdrdy[d] = (rdy && win >= 0) ? 4'(1 << win) : 4'b0;
      exp_psrdy[d] = m_valid[d];
      x = rdy && (win >= 0) && srdy[d][win];
      m_xfer[d] = x;
      m_win[d]  = win;
      if (x) begin
        item_t it;
        it.grant = 4'(1 << win);
        it.data  = wd[d][win];
        it.eop   = eop[d][win];
        sb_push(d, it);
        m_last[d] = win;
        if (mode_of[d] == 1) begin
          m_lock[d] = !eop[d][win];
          m_lidx[d] = win;
        end
      end
      m_valid[d] = x || (m_valid[d] && !pdrdy[d]);
    end
    mon_en = 1'b1;
  endtask

  // Called just after a rising edge with inputs set; returns just after the next one.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      srdy[d]    = '0;
      m_last[d]  = n_of[d] - 1;
      m_lock[d]  = 1'b0;
      m_lidx[d]  = 0;
      m_valid[d] = 1'b0;
    end
    sbq0.delete();
    sbq1.delete();
    for (int i = 0; i < 3; i++) wcnt[i] = 0;
    #1;
    chk("rst_a_p_srdy", 32'(a_p_srdy), 0);
    chk("rst_a_p_grant", 32'(a_p_grant), 0);
    chk("rst_a_p_eop", 32'(a_p_eop), 0);
    chk("rst_b_p_srdy", 32'(b_p_srdy), 0);
    chk("rst_b_p_grant", 32'(b_p_grant), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_inputs(bit first);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < n_of[d]; i++) begin
        if (first || (m_xfer[d] && m_win[d] == i)) begin
          wd[d][i]  = 8'($urandom);
          eop[d][i] = ($urandom_range(0, 2) == 0);
        end
        srdy[d][i] = ($urandom_range(0, 3) != 0);
      end
      pdrdy[d] = ($urandom_range(0, 9) < 7);
    end
  endtask

  // Monitor: handshake checks and scoreboard pops, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("c_drdy[%0d]", d), 32'(o_cdrdy[d]), 32'(exp_cdrdy[d]));
        chk($sformatf("p_srdy[%0d]", d), 32'(o_psrdy[d]), 32'(exp_psrdy[d]));
        if (o_psrdy[d] && pdrdy[d]) begin
          if (sb_size(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow[%0d]: actual=1 word expected=0 words", d);
          end else begin
            item_t it;
            it = sb_pop(d);
            chk($sformatf("p_grant[%0d]", d), 32'(o_grant[d]), 32'(it.grant));
            chk($sformatf("p_data[%0d]", d), 32'(o_pdata[d]), 32'(it.data));
            chk($sformatf("p_eop[%0d]", d), 32'(o_peop[d]), 32'(it.eop));
          end
        end
      end
      // Word-mode fairness: a continuously requesting input waits at most inputs-1 grants.
      for (int i = 0; i < 3; i++) begin
        if (!srdy[1][i]) begin
          wcnt[i] = 0;
        end else if (b_c_drdy[i]) begin
          chk($sformatf("starve[%0d]", i), 32'(wcnt[i] <= 2), 1);
          wcnt[i] = 0;
        end else if (|(b_c_srdy & b_c_drdy)) begin
          wcnt[i]++;
        end
      end
    end
  end

  logic [3:0] fair_seq[5];

  initial begin
    reset_n = 1'b0;
    mon_en  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      srdy[d]  = '0;
      eop[d]   = '0;
      pdrdy[d] = 1'b0;
      for (int i = 0; i < 4; i++) wd[d][i] = '0;
    end
    fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Fairness on A, all requesting, eop on every word so no locking.
    do_reset();
    srdy[0]  = 4'hF;
    eop[0]   = 4'hF;
    pdrdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) wd[0][i] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("fair_grant%0d", k), 32'(a_p_grant), 32'(fair_seq[k]));
      chk($sformatf("fair_srdy%0d", k), 32'(a_p_srdy), 1);
    end

    // Backpressure on A.
    do_reset();
    eop[0]   = 4'hF;
    pdrdy[0] = 1'b1;
    wd[0][0] = 8'h5A;
    srdy[0]  = 4'b0001;
    step();
    chk("bp_load", 32'(a_p_data), 32'h5A);
    srdy[0]  = 4'b0100;
    wd[0][2] = 8'hC3;
    pdrdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_cdrdy_blocked", 32'(a_c_drdy), 0);
      chk("bp_hold", 32'(a_p_data), 32'h5A);
      step();
    end
    pdrdy[0] = 1'b1;
    #1;
    chk("bp_cdrdy_open", 32'(a_c_drdy), 32'b0100);
    step();
    chk("bp_next_data", 32'(a_p_data), 32'hC3);
    chk("bp_next_grant", 32'(a_p_grant), 32'b0100);

    // Packet lock on A: requester 1 sends 3 words, requester 0 waits.
    do_reset();
    pdrdy[0] = 1'b1;
    wd[0][0] = 8'hB0;
    eop[0]   = 4'b0001;
    wd[0][1] = 8'hA1;
    srdy[0]  = 4'b0010;
    step();
    chk("pkt_g1", 32'(a_p_grant), 32'b0010);
    wd[0][1] = 8'hA2;
    srdy[0]  = 4'b0011;
    step();
    chk("pkt_g2", 32'(a_p_grant), 32'b0010);
    chk("pkt_d2", 32'(a_p_data), 32'hA2);
    srdy[0]  = 4'b0001;
    #1;
    chk("pkt_gap_no0", 32'(a_c_drdy[0]), 0);
    step();
    chk("pkt_gap_srdy", 32'(a_p_srdy), 0);
    wd[0][1] = 8'hA3;
    eop[0]   = 4'b0011;
    srdy[0]  = 4'b0011;
    step();
    chk("pkt_g3", 32'(a_p_grant), 32'b0010);
    chk("pkt_eop3", 32'(a_p_eop), 1);
    srdy[0]  = 4'b0001;
    step();
    chk("pkt_g4", 32'(a_p_grant), 32'b0001);
    chk("pkt_d4", 32'(a_p_data), 32'hB0);

    // Reset mid-packet on A with lock held by requester 3.
    do_reset();
    pdrdy[0] = 1'b0;
    wd[0][3] = 8'hD0;
    eop[0]   = 4'b0000;
    srdy[0]  = 4'b1000;
    step();
    chk("mid_locked_grant", 32'(a_p_grant), 32'b1000);
    #2;
    do_reset();
    eop[0]   = 4'hF;
    pdrdy[0] = 1'b1;
    srdy[0]  = 4'b1010;
    step();
    chk("mid_after_rst", 32'(a_p_grant), 32'b0010);

    // Wrap on B (3 inputs) and no locking in word mode.
    do_reset();
    pdrdy[1] = 1'b1;
    eop[1]   = 4'b0000;
    wd[1][0] = 8'h30;
    wd[1][1] = 8'h31;
    wd[1][2] = 8'h32;
    srdy[1]  = 4'b0101;
    step();
    chk("wrap_g0", 32'(b_p_grant), 32'b001);
    chk("wrap_d0", 32'(b_p_data), 32'h30);
    step();
    chk("wrap_g2", 32'(b_p_grant), 32'b100);
    chk("wrap_d2", 32'(b_p_data), 32'h32);
    srdy[1]  = 4'b0011;
    step();
    chk("nolock_g0", 32'(b_p_grant), 32'b001);
    step();
    chk("nolock_g1", 32'(b_p_grant), 32'b010);
    step();
    chk("nolock_g0b", 32'(b_p_grant), 32'b001);

    // Randomized traffic on both instances.
    do_reset();
    rand_inputs(1'b1);
    for (int c = 0; c < 10000; c++) begin
      step();
      rand_inputs(1'b0);
    end
    for (int d = 0; d < 2; d++) begin
      srdy[d]  = '0;
      pdrdy[d] = 1'b1;
    end
    for (int c = 0; c < 4; c++) step();
    chk("sb_empty_a", 32'(sb_size(0)), 0);
    chk("sb_empty_b", 32'(sb_size(1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
